// File: rtl/hex_dbg_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_dbg_if
// Brief    : Capture bus for hex_debug_display (channel words, strobes, freeze)
// Revision : 1.0 - initial release
// ============================================================================
interface hex_dbg_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32
);
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic                   freeze;

    modport master (output ch_data, ch_valid, freeze);
    modport slave  (input  ch_data, ch_valid, freeze);
endinterface
`default_nettype wire

// File: rtl/hex_debug_display.sv
`default_nettype none
// ============================================================================
// Module   : hex_debug_display
// Brief    : Multi-channel debug word capture shown as hex on 7-segment digits.
//            Optional macro HEX_DBG_LEADING_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module hex_debug_display #(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 32,
    parameter int N_DIGITS     = 8,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLINK_CYC    = 5000000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    hex_dbg_if.slave                                  cap_bus,
    input  logic                                      key_next,
    output logic [N_DIGITS*7-1:0]                     hex_out,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cur_ch,
    output logic                                      upd_led
);
    localparam int c_SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_NIB   = DATA_W / 4;
    localparam int c_DB_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int c_BL_W  = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Display contents for an all-zero selected word.
    function automatic logic [N_DIGITS*7-1:0] f_rst_hex();
        logic [N_DIGITS*7-1:0] v;
        v = '1;
        for (int d = 0; d < N_DIGITS; d++) begin
`ifdef HEX_DBG_LEADING_BLANK_EN
            if (d == 0 && c_NIB > 0) v[d*7 +: 7] = 7'h40;
`else
            if (d < c_NIB) v[d*7 +: 7] = 7'h40;
`endif
        end
        return v;
    endfunction

    localparam logic [N_DIGITS*7-1:0] c_HEX_RST = f_rst_hex();

    logic [DATA_W-1:0]     r_cap [N_CH];
    logic                  r_key_s1, r_key_s2, r_key_db, r_press;
    logic [c_DB_W-1:0]     r_db_cnt;
    logic [c_BL_W-1:0]     r_blink_cnt;
    logic                  w_sel_cap;
    logic [DATA_W-1:0]     w_sel;
    logic [N_DIGITS*7-1:0] w_hex;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) r_cap[k] <= '0;
        end else if (!cap_bus.freeze) begin
            for (int k = 0; k < N_CH; k++)
                if (cap_bus.ch_valid[k]) r_cap[k] <= cap_bus.ch_data[k*DATA_W +: DATA_W];
        end
    end

    // The counter only runs while the synced key disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_key_db <= 1'b1;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_key_s1 <= key_next;
            r_key_s2 <= r_key_s1;
            r_press  <= 1'b0;
            if (r_key_s2 == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_W'(DEBOUNCE_CYC - 1)) begin
                r_key_db <= r_key_s2;
                r_db_cnt <= '0;
                r_press  <= ~r_key_s2;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cur_ch <= '0;
        else if (r_press)
            cur_ch <= (cur_ch == c_SEL_W'(N_CH - 1)) ? '0 : cur_ch + c_SEL_W'(1);
    end

    assign w_sel_cap = cap_bus.ch_valid[cur_ch] && !cap_bus.freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            upd_led     <= 1'b0;
        end else if (w_sel_cap) begin
            r_blink_cnt <= c_BL_W'(BLINK_CYC - 1);
            upd_led     <= 1'b1;
        end else begin
            upd_led <= (r_blink_cnt != '0);
            if (r_blink_cnt != '0) r_blink_cnt <= r_blink_cnt - c_BL_W'(1);
        end
    end

    assign w_sel = r_cap[cur_ch];

    generate
        for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
            if (d < c_NIB) begin : g_shown
                logic [3:0] w_nib;
                assign w_nib = w_sel[d*4 +: 4];
`ifdef HEX_DBG_LEADING_BLANK_EN
                if (d == 0) begin : g_lsd
                    assign w_hex[d*7 +: 7] = f_seg(w_nib);
                end else begin : g_upper
                    logic w_hi_zero;
                    assign w_hi_zero = ~|w_sel[DATA_W-1:d*4];
                    assign w_hex[d*7 +: 7] = w_hi_zero ? 7'h7F : f_seg(w_nib);
                end
`else
                assign w_hex[d*7 +: 7] = f_seg(w_nib);
`endif
            end else begin : g_blank
                assign w_hex[d*7 +: 7] = 7'h7F;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hex_out <= c_HEX_RST;
        else      hex_out <= w_hex;
    end
endmodule
`default_nettype wire

// File: tb/tb_hex_debug_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_debug_display
// Brief    : Self-checking bench for hex_debug_display against a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_debug_display;
    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int ND   = 8;
    localparam int DB   = 4;
    localparam int BL   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_next = 1'b1;
    always #5 clk = ~clk;

    hex_dbg_if #(.N_CH(N_CH), .DATA_W(DW)) bus ();
    logic [ND*7-1:0] hex_out;
    logic [1:0]      cur_ch;
    logic            upd_led;

    hex_debug_display #(.N_CH(N_CH), .DATA_W(DW), .N_DIGITS(ND),
                        .DEBOUNCE_CYC(DB), .BLINK_CYC(BL)) dut (
        .clk(clk), .rst(rst), .cap_bus(bus), .key_next(key_next),
        .hex_out(hex_out), .cur_ch(cur_ch), .upd_led(upd_led));

    hex_dbg_if #(.N_CH(2), .DATA_W(16)) bus2 ();
    logic [41:0] hex2;
    logic        cur2;
    logic        led2;

    hex_debug_display #(.N_CH(2), .DATA_W(16), .N_DIGITS(6),
                        .DEBOUNCE_CYC(DB), .BLINK_CYC(BL)) dut2 (
        .clk(clk), .rst(rst), .cap_bus(bus2), .key_next(1'b1),
        .hex_out(hex2), .cur_ch(cur2), .upd_led(led2));

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] cap_m [N_CH];
    int            cur_m = 0;
    int            cyc = 0;
    int            last_cap = -1000;
    logic [6:0]    seg_tab [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // What a display of the given width should show for a word.
    function automatic logic [63:0] fdisp(input logic [63:0] val, input int dw, input int nd);
        logic [63:0] r;
        r = '0;
        for (int d = 0; d < nd; d++) begin
            logic [6:0]  s;
            logic [63:0] hi;
            hi = val >> (4 * d);
            if (d >= dw / 4) s = 7'h7F;
            else begin
                s = seg_tab[int'(hi & 64'hF)];
`ifdef HEX_DBG_LEADING_BLANK_EN
                if (d > 0 && hi == 64'd0) s = 7'h7F;
`endif
            end
            r[d*7 +: 7] = s;
        end
        return r;
    endfunction

    task automatic step(input logic [N_CH-1:0] v, input logic [N_CH*DW-1:0] d,
                        input logic frz, input bit chk);
        logic [63:0] exp_hex;
        bus.ch_valid = v;
        bus.ch_data  = d;
        bus.freeze   = frz;
        @(posedge clk);
        exp_hex = fdisp(64'(cap_m[cur_m]), DW, ND);
        if (!frz) begin
            for (int k = 0; k < N_CH; k++)
                if (v[k]) cap_m[k] = d[k*DW +: DW];
            if (v[cur_m]) last_cap = cyc;
        end
        #1;
        bus.ch_valid = '0;
        if (chk) begin
            check("hex", 64'(hex_out), exp_hex);
            check("led", 64'(upd_led), 64'((cyc - last_cap) < BL));
            check("cur", 64'(cur_ch), 64'(cur_m));
        end
        cyc++;
    endtask

    task automatic key_cycles(input logic lvl, input int n);
        key_next = lvl;
        repeat (n) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic press();
        key_cycles(1'b0, 10);
        key_cycles(1'b1, 10);
        cur_m = (cur_m + 1) % N_CH;
        check("press_cur", 64'(cur_ch), 64'(cur_m));
    endtask

    initial begin
        logic [N_CH*DW-1:0] rd;
        logic [N_CH-1:0]    rv;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int k = 0; k < N_CH; k++) cap_m[k] = '0;
        bus.ch_valid = '0; bus.ch_data = '0; bus.freeze = 1'b0;
        bus2.ch_valid = '0; bus2.ch_data = '0; bus2.freeze = 1'b0;

        #23;
        check("rst_hex", 64'(hex_out), fdisp(64'd0, DW, ND));
        check("rst_cur", 64'(cur_ch), 64'd0);
        check("rst_led", 64'(upd_led), 64'd0);
        check("rst_hex2", 64'(hex2), fdisp(64'd0, 16, 6));
        @(negedge clk);
        rst = 1'b1;

        bus2.ch_valid = 2'b01;
        bus2.ch_data  = {16'h0000, 16'hBEEF};
        step(4'b0001, {96'h0, 32'h1234ABCD}, 1'b0, 1'b1);
        bus2.ch_valid = '0;
        step('0, '0, 1'b0, 1'b1);
        check("abcd_digits", 64'(hex_out),
              64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}));
        check("beef_digits", 64'(hex2), 64'({7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}));
        repeat (BL + 2) step('0, '0, 1'b0, 1'b1);

        step(4'b0001, {96'h0, 32'hFFFFFFFF}, 1'b1, 1'b1);
        repeat (3) step(4'b0001, {96'h0, 32'hFFFFFFFF}, 1'b1, 1'b1);
        check("freeze_hold", 64'(hex_out),
              64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}));
        step(4'b0001, {96'h0, 32'h0000000F}, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
`ifdef HEX_DBG_LEADING_BLANK_EN
        check("f_digits", 64'(hex_out), 64'({{7{7'h7F}}, 7'h0E}));
        step(4'b0001, {96'h0, 32'h0000002A}, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        check("blank_2a", 64'(hex_out), 64'({{6{7'h7F}}, 7'h24, 7'h08}));
        step(4'b0001, {96'h0, 32'h00000000}, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        check("blank_zero", 64'(hex_out), 64'({{7{7'h7F}}, 7'h40}));
`else
        check("f_digits", 64'(hex_out), 64'({{7{7'h40}}, 7'h0E}));
`endif

        for (int i = 0; i < 5; i++) begin
            key_cycles(1'b0, 2);
            key_cycles(1'b1, 2);
        end
        key_cycles(1'b1, 8);
        check("bounce_cur", 64'(cur_ch), 64'd0);
        press();
        press();
        press();
        press();

        for (int r = 0; r < N_CH; r++) begin
            for (int i = 0; i < 30; i++) begin
                rd = {$urandom(), $urandom(), $urandom(), $urandom()};
                if ($urandom_range(0, 1) == 1)
                    rd = rd & {32'h000000FF, 32'h0000FFFF, 32'h00000FFF, 32'h0000000F};
                rv = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                step(rv, rd, ($urandom_range(0, 4) == 0), 1'b1);
            end
            press();
            step('0, '0, 1'b0, 1'b1);
        end
        press();
        press();
        press();

        step(4'b1000, {32'hCAFE0001, 96'h0}, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_hex", 64'(hex_out), fdisp(64'd0, DW, ND));
        check("async_rst_cur", 64'(cur_ch), 64'd0);
        check("async_rst_led", 64'(upd_led), 64'd0);
        check("async_rst_hex2", 64'(hex2), fdisp(64'd0, 16, 6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
